// File: rtl/alu_unit_pkg.sv
// alu_unit_pkg: op encoding, issue bundle and divide helpers
// shared by the ALU execution stage and its divider.
package alu_unit_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int ROB_W = 4;

  typedef logic [ROB_W-1:0] ROB_INDEX_TYPE;
  typedef logic [31:0]      DATA_TYPE;
  typedef logic [31:0]      ADDR_TYPE;

  typedef enum logic [5:0] {
    OP_NONE,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
    OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } OPENUM_TYPE;

  typedef struct packed {
    OPENUM_TYPE    op;
    DATA_TYPE      rs1;
    DATA_TYPE      rs2;
    ROB_INDEX_TYPE rob;
    ADDR_TYPE      pc;
    DATA_TYPE      imm;
  } alu_req_t;

  function automatic logic op_uses_imm(OPENUM_TYPE op);
    return op inside {OP_ADDI, OP_SLTI, OP_SLTIU,
                      OP_XORI, OP_ORI, OP_ANDI,
                      OP_SLLI, OP_SRLI, OP_SRAI};
  endfunction

  function automatic logic op_is_br(OPENUM_TYPE op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT,
                      OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

  function automatic logic op_is_mul(OPENUM_TYPE op);
    return op inside {OP_MUL, OP_MULH,
                      OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic op_is_div(OPENUM_TYPE op);
    return op inside {OP_DIV, OP_DIVU,
                      OP_REM, OP_REMU};
  endfunction

  function automatic logic div_signed(OPENUM_TYPE op);
    return op inside {OP_DIV, OP_REM};
  endfunction

  function automatic logic div_is_rem(OPENUM_TYPE op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // Divide-by-zero or signed 0x80000000 / -1.
  function automatic logic div_special(
    OPENUM_TYPE op, DATA_TYPE a, DATA_TYPE b);
    return (b == '0) ||
           (div_signed(op) && a == 32'h8000_0000 &&
            b == 32'hFFFF_FFFF);
  endfunction

  function automatic DATA_TYPE div_special_res(
    OPENUM_TYPE op, DATA_TYPE a, DATA_TYPE b);
    if (b == '0)
      return div_is_rem(op) ? a : 32'hFFFF_FFFF;
    return div_is_rem(op) ? 32'h0 : 32'h8000_0000;
  endfunction

endpackage

// File: rtl/alu_divider.sv
// alu_divider: iterative restoring divider, one quotient bit
// per cycle, with sign fix and div-by-zero/overflow results.
module alu_divider
  import alu_unit_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic       i_start,
  input  OPENUM_TYPE i_op,
  input  DATA_TYPE   i_a,
  input  DATA_TYPE   i_b,
  output logic       o_last,
  output DATA_TYPE   o_result
);

  localparam int CW = $clog2(DIV_ITERS + 1);

  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic          r_qneg;
  logic          r_rneg;
  logic          r_rsel;
  logic          r_spec;
  DATA_TYPE      r_spec_res;
  DATA_TYPE      r_quo;
  DATA_TYPE      r_rem;
  DATA_TYPE      r_div;

  logic          w_sa;
  logic          w_sb;
  logic [32:0]   w_sh;
  logic          w_ge;
  DATA_TYPE      w_diff;
  DATA_TYPE      w_q;
  DATA_TYPE      w_r;

  assign w_sa = div_signed(i_op) && i_a[31];
  assign w_sb = div_signed(i_op) && i_b[31];

  assign w_sh   = {r_rem, r_quo[31]};
  assign w_ge   = w_sh >= {1'b0, r_div};
  assign w_diff = w_sh[31:0] - r_div;

  always_ff @(posedge clk_in) begin
    if (rst_in || i_clr) begin
      r_run      <= FALSE;
      r_cnt      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_qneg     <= FALSE;
      r_rneg     <= FALSE;
      r_rsel     <= FALSE;
      r_spec     <= FALSE;
      r_spec_res <= '0;
    end else if (i_en) begin
      if (i_start) begin
        r_run      <= TRUE;
        r_cnt      <= CW'(DIV_ITERS);
        r_quo      <= w_sa ? -i_a : i_a;
        r_rem      <= '0;
        r_div      <= w_sb ? -i_b : i_b;
        r_qneg     <= w_sa ^ w_sb;
        r_rneg     <= w_sa;
        r_rsel     <= div_is_rem(i_op);
        r_spec     <= div_special(i_op, i_a, i_b);
        r_spec_res <= div_special_res(i_op, i_a, i_b);
      end else if (r_run) begin
        r_quo <= {r_quo[30:0], w_ge};
        r_rem <= w_ge ? w_diff : w_sh[31:0];
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1))
          r_run <= FALSE;
      end
    end
  end

  assign o_last = r_run && (r_cnt == CW'(1));

  assign w_q = r_qneg ? -r_quo : r_quo;
  assign w_r = r_rneg ? -r_rem : r_rem;

  assign o_result = r_spec ? r_spec_res :
                    r_rsel ? w_r : w_q;

endmodule

// File: rtl/alu_unit.sv
// alu_unit: RV32IM execution stage with one-entry skid buffer.
// ALU_DIV_BYPASS_EN: div-by-zero/overflow finish in one cycle.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int DIV_ITERS = 32,
  parameter int MUL_LAT   = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clr_in,
  input  logic          rs_to_alu_ready,
  input  OPENUM_TYPE    rs_to_alu_op,
  input  DATA_TYPE      rs_to_alu_rs1,
  input  DATA_TYPE      rs_to_alu_rs2,
  input  ROB_INDEX_TYPE rs_to_alu_rob_index,
  input  ADDR_TYPE      rs_to_alu_PC,
  input  DATA_TYPE      rs_to_alu_imm,
  output logic          alu_busy,
  output logic          alu_ready,
  output DATA_TYPE      alu_result,
  output ROB_INDEX_TYPE alu_rob_index,
  output logic          alu_is_br,
  output logic          alu_taken,
  output ADDR_TYPE      alu_target
);

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;

  alu_req_t      w_in;
  alu_req_t      w_req;
  alu_req_t      r_skid;
  logic          r_skid_v;

  logic          r_ready;
  DATA_TYPE      r_result;
  ROB_INDEX_TYPE r_rob;
  logic          r_is_br;
  logic          r_taken;
  ADDR_TYPE      r_target;

  logic [7:0]    r_mcnt;
  logic [63:0]   r_prod;
  logic          r_mhi;
  ROB_INDEX_TYPE r_prob;

  logic          w_accept;
  logic          w_is_mul;
  logic          w_is_div;
  logic          w_byp;
  logic          w_multi;
  logic          w_div_start;
  logic          w_div_last;
  DATA_TYPE      w_div_res;

  DATA_TYPE      w_b;
  logic [4:0]    w_sh;
  ADDR_TYPE      w_pc4;
  ADDR_TYPE      w_pci;
  ADDR_TYPE      w_jr;
  DATA_TYPE      w_res;
  logic          w_cond;
  logic          w_is_br;
  logic          w_taken;
  ADDR_TYPE      w_target;

  logic          w_sa;
  logic          w_sb;
  logic [63:0]   w_a64;
  logic [63:0]   w_b64;
  logic [63:0]   w_prod;

  assign w_in.op  = rs_to_alu_op;
  assign w_in.rs1 = rs_to_alu_rs1;
  assign w_in.rs2 = rs_to_alu_rs2;
  assign w_in.rob = rs_to_alu_rob_index;
  assign w_in.pc  = rs_to_alu_PC;
  assign w_in.imm = rs_to_alu_imm;

  // The skid entry is always older than a new arrival.
  assign w_req = r_skid_v ? r_skid : w_in;

  assign w_accept = rdy_in && !rst_in && !clr_in &&
                    (r_state == S_IDLE) &&
                    (r_skid_v || rs_to_alu_ready);

  assign w_is_mul = op_is_mul(w_req.op);
  assign w_is_div = op_is_div(w_req.op);

`ifdef ALU_DIV_BYPASS_EN
  assign w_byp = w_is_div &&
    div_special(w_req.op, w_req.rs1, w_req.rs2);
`else
  assign w_byp = FALSE;
`endif

  assign w_multi     = w_is_mul || (w_is_div && !w_byp);
  assign w_div_start = w_accept && w_is_div && !w_byp;

  assign alu_busy = (r_state != S_IDLE) || r_skid_v ||
                    (w_accept && w_multi);

  assign w_b   = op_uses_imm(w_req.op) ?
                 w_req.imm : w_req.rs2;
  assign w_sh  = w_b[4:0];
  assign w_pc4 = w_req.pc + 32'd4;
  assign w_pci = w_req.pc + w_req.imm;
  assign w_jr  = w_req.rs1 + w_req.imm;

  always_comb begin
    w_res    = '0;
    w_cond   = FALSE;
    w_is_br  = FALSE;
    w_taken  = FALSE;
    w_target = '0;
    unique case (w_req.op)
      OP_ADD, OP_ADDI:   w_res = w_req.rs1 + w_b;
      OP_SUB:            w_res = w_req.rs1 - w_b;
      OP_SLL, OP_SLLI:   w_res = w_req.rs1 << w_sh;
      OP_SLT, OP_SLTI:
        w_res = {31'b0,
                 $signed(w_req.rs1) < $signed(w_b)};
      OP_SLTU, OP_SLTIU:
        w_res = {31'b0, w_req.rs1 < w_b};
      OP_XOR, OP_XORI:   w_res = w_req.rs1 ^ w_b;
      OP_SRL, OP_SRLI:   w_res = w_req.rs1 >> w_sh;
      OP_SRA, OP_SRAI:
        w_res = $unsigned($signed(w_req.rs1) >>> w_sh);
      OP_OR, OP_ORI:     w_res = w_req.rs1 | w_b;
      OP_AND, OP_ANDI:   w_res = w_req.rs1 & w_b;
      OP_LUI:            w_res = w_req.imm;
      OP_AUIPC:          w_res = w_pci;
      OP_JAL: begin
        w_res    = w_pc4;
        w_is_br  = TRUE;
        w_taken  = TRUE;
        w_target = w_pci;
      end
      OP_JALR: begin
        w_res    = w_pc4;
        w_is_br  = TRUE;
        w_taken  = TRUE;
        w_target = w_jr & ~32'd1;
      end
      OP_BEQ:  w_cond = w_req.rs1 == w_req.rs2;
      OP_BNE:  w_cond = w_req.rs1 != w_req.rs2;
      OP_BLT:
        w_cond = $signed(w_req.rs1) < $signed(w_req.rs2);
      OP_BGE:
        w_cond = $signed(w_req.rs1) >= $signed(w_req.rs2);
      OP_BLTU: w_cond = w_req.rs1 < w_req.rs2;
      OP_BGEU: w_cond = w_req.rs1 >= w_req.rs2;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU:
        w_res = div_special_res(w_req.op,
                                w_req.rs1, w_req.rs2);
      default: ;
    endcase
    if (op_is_br(w_req.op)) begin
      w_is_br  = TRUE;
      w_taken  = w_cond;
      w_target = w_cond ? w_pci : w_pc4;
    end
  end

  // 33-bit extended operands, widened to 64 for the product.
  assign w_sa = (w_req.op inside {OP_MULH, OP_MULHSU}) &&
                w_req.rs1[31];
  assign w_sb = (w_req.op == OP_MULH) && w_req.rs2[31];
  assign w_a64  = {{32{w_sa}}, w_req.rs1};
  assign w_b64  = {{32{w_sb}}, w_req.rs2};
  assign w_prod = w_a64 * w_b64;

  alu_divider #(
    .DIV_ITERS (DIV_ITERS)
  ) u_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .i_en     (rdy_in),
    .i_clr    (clr_in),
    .i_start  (w_div_start),
    .i_op     (w_req.op),
    .i_a      (w_req.rs1),
    .i_b      (w_req.rs2),
    .o_last   (w_div_last),
    .o_result (w_div_res)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept && w_is_mul)
          w_next = S_MUL;
        else if (w_div_start)
          w_next = S_DIV;
      S_MUL:
        if (r_mcnt == '0)
          w_next = S_IDLE;
      S_DIV:
        if (w_div_last)
          w_next = S_DONE;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in)
      r_state <= S_IDLE;
    else if (rdy_in)
      r_state <= w_next;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      r_skid_v <= FALSE;
      r_skid   <= '0;
    end else if (rdy_in) begin
      if (r_state != S_IDLE) begin
        if (rs_to_alu_ready && !r_skid_v) begin
          r_skid_v <= TRUE;
          r_skid   <= w_in;
        end
      end else if (r_skid_v) begin
        r_skid_v <= rs_to_alu_ready;
        if (rs_to_alu_ready)
          r_skid <= w_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      r_mcnt <= '0;
      r_prod <= '0;
      r_mhi  <= FALSE;
      r_prob <= '0;
    end else if (rdy_in) begin
      if (w_accept && w_multi) begin
        r_mcnt <= 8'(MUL_LAT - 2);
        r_prod <= w_prod;
        r_mhi  <= w_req.op != OP_MUL;
        r_prob <= w_req.rob;
      end else if (r_state == S_MUL && r_mcnt != '0) begin
        r_mcnt <= r_mcnt - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      r_ready  <= FALSE;
      r_result <= '0;
      r_rob    <= '0;
      r_is_br  <= FALSE;
      r_taken  <= FALSE;
      r_target <= '0;
    end else if (rdy_in) begin
      r_ready <= FALSE;
      if (w_accept && !w_multi) begin
        r_ready  <= TRUE;
        r_result <= w_res;
        r_rob    <= w_req.rob;
        r_is_br  <= w_is_br;
        r_taken  <= w_taken;
        r_target <= w_target;
      end else if (r_state == S_MUL && r_mcnt == '0) begin
        r_ready  <= TRUE;
        r_result <= r_mhi ? r_prod[63:32] : r_prod[31:0];
        r_rob    <= r_prob;
        r_is_br  <= FALSE;
        r_taken  <= FALSE;
        r_target <= '0;
      end else if (r_state == S_DONE) begin
        r_ready  <= TRUE;
        r_result <= w_div_res;
        r_rob    <= r_prob;
        r_is_br  <= FALSE;
        r_taken  <= FALSE;
        r_target <= '0;
      end
    end
  end

  assign alu_ready     = r_ready;
  assign alu_result    = r_result;
  assign alu_rob_index = r_rob;
  assign alu_is_br     = r_is_br;
  assign alu_taken     = r_taken;
  assign alu_target    = r_target;

  // A second arrival may only land while the skid drains.
  a_skid_ovf: assert property (
    @(posedge clk_in) disable iff (rst_in || clr_in)
    (rdy_in && rs_to_alu_ready && r_skid_v)
      |-> (r_state == S_IDLE));

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed vectors with hand-computed results
// for the ALU execution stage.
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          clr_in;
  logic          rs_to_alu_ready;
  OPENUM_TYPE    rs_to_alu_op;
  DATA_TYPE      rs_to_alu_rs1;
  DATA_TYPE      rs_to_alu_rs2;
  ROB_INDEX_TYPE rs_to_alu_rob_index;
  ADDR_TYPE      rs_to_alu_PC;
  DATA_TYPE      rs_to_alu_imm;
  logic          alu_busy;
  logic          alu_ready;
  DATA_TYPE      alu_result;
  ROB_INDEX_TYPE alu_rob_index;
  logic          alu_is_br;
  logic          alu_taken;
  ADDR_TYPE      alu_target;

  int n_chk = 0;
  int n_err = 0;
  int lat;
  int cnt;

`ifdef ALU_DIV_BYPASS_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 34;
`endif

  alu_unit dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .clr_in              (clr_in),
    .rs_to_alu_ready     (rs_to_alu_ready),
    .rs_to_alu_op        (rs_to_alu_op),
    .rs_to_alu_rs1       (rs_to_alu_rs1),
    .rs_to_alu_rs2       (rs_to_alu_rs2),
    .rs_to_alu_rob_index (rs_to_alu_rob_index),
    .rs_to_alu_PC        (rs_to_alu_PC),
    .rs_to_alu_imm       (rs_to_alu_imm),
    .alu_busy            (alu_busy),
    .alu_ready           (alu_ready),
    .alu_result          (alu_result),
    .alu_rob_index       (alu_rob_index),
    .alu_is_br           (alu_is_br),
    .alu_taken           (alu_taken),
    .alu_target          (alu_target)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input OPENUM_TYPE op,
                       input DATA_TYPE a,
                       input DATA_TYPE b,
                       input ADDR_TYPE pc,
                       input DATA_TYPE imm,
                       input ROB_INDEX_TYPE rob);
    rs_to_alu_ready     = 1'b1;
    rs_to_alu_op        = op;
    rs_to_alu_rs1       = a;
    rs_to_alu_rs2       = b;
    rs_to_alu_PC        = pc;
    rs_to_alu_imm       = imm;
    rs_to_alu_rob_index = rob;
  endtask

  task automatic wait_rdy(input int start, output int l);
    l = start;
    while (!alu_ready && l < 200) begin
      @(negedge clk_in);
      l++;
    end
    check("timeout", {31'b0, alu_ready}, 32'd1);
  endtask

  task automatic run(input OPENUM_TYPE op,
                     input DATA_TYPE a,
                     input DATA_TYPE b,
                     input ADDR_TYPE pc,
                     input DATA_TYPE imm,
                     input ROB_INDEX_TYPE rob,
                     output int l);
    drive(op, a, b, pc, imm, rob);
    @(negedge clk_in);
    rs_to_alu_ready = 1'b0;
    wait_rdy(1, l);
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clr_in = 1'b0;
    drive(OP_ADD, 0, 0, 0, 0, 0);
    rs_to_alu_ready = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_ready", {31'b0, alu_ready}, 0);
    check("rst_busy", {31'b0, alu_busy}, 0);
    check("rst_result", alu_result, 0);
    check("rst_target", alu_target, 0);
    check("rst_rob", 32'(alu_rob_index), 0);
    @(negedge clk_in);

    run(OP_ADD, 5, 32'hFFFF_FFFD, 0, 0, 3, lat);
    check("add_lat", lat, 1);
    check("add_res", alu_result, 2);
    check("add_rob", 32'(alu_rob_index), 3);
    check("add_br", {31'b0, alu_is_br}, 0);

    run(OP_SRA, 32'h8000_0000, 4, 0, 0, 1, lat);
    check("sra_res", alu_result, 32'hF800_0000);

    run(OP_ADDI, 10, 99, 0, 32'hFFFF_FFFF, 2, lat);
    check("addi_res", alu_result, 9);
    run(OP_SLTU, 1, 32'hFFFF_FFFF, 0, 0, 2, lat);
    check("sltu_res", alu_result, 1);
    run(OP_SLT, 1, 32'hFFFF_FFFF, 0, 0, 2, lat);
    check("slt_res", alu_result, 0);
    run(OP_LUI, 0, 0, 0, 32'h1234_5000, 2, lat);
    check("lui_res", alu_result, 32'h1234_5000);
    run(OP_AUIPC, 0, 0, 32'h1000, 32'h2000, 2, lat);
    check("auipc_res", alu_result, 32'h3000);

    run(OP_BLT, 32'hFFFF_FFFF, 0, 32'h100, 32'h20, 4, lat);
    check("blt_br", {31'b0, alu_is_br}, 1);
    check("blt_tk", {31'b0, alu_taken}, 1);
    check("blt_tgt", alu_target, 32'h120);
    check("blt_res", alu_result, 0);
    run(OP_BGEU, 32'hFFFF_FFFF, 0, 32'h100, 32'h20, 4, lat);
    check("bgeu_tk", {31'b0, alu_taken}, 1);
    check("bgeu_tgt", alu_target, 32'h120);
    run(OP_BEQ, 32'hFFFF_FFFF, 0, 32'h100, 32'h20, 4, lat);
    check("beq_br", {31'b0, alu_is_br}, 1);
    check("beq_tk", {31'b0, alu_taken}, 0);
    check("beq_tgt", alu_target, 32'h104);
    run(OP_JALR, 32'h203, 0, 32'h100, 0, 5, lat);
    check("jalr_res", alu_result, 32'h104);
    check("jalr_tgt", alu_target, 32'h202);
    check("jalr_tk", {31'b0, alu_taken}, 1);
    run(OP_JAL, 0, 0, 32'h40, 32'h10, 5, lat);
    check("jal_res", alu_result, 32'h44);
    check("jal_tgt", alu_target, 32'h50);

    drive(OP_MULH, 32'h8000_0000, 32'h8000_0000, 0, 0, 6);
    #1;
    check("mul_busy0", {31'b0, alu_busy}, 1);
    @(negedge clk_in);
    rs_to_alu_ready = 1'b0;
    check("mul_busy1", {31'b0, alu_busy}, 1);
    check("mul_early", {31'b0, alu_ready}, 0);
    wait_rdy(1, lat);
    check("mulh_lat", lat, 2);
    check("mulh_res", alu_result, 32'h4000_0000);
    check("mulh_rob", 32'(alu_rob_index), 6);
    run(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 6, lat);
    check("mulhu_res", alu_result, 32'hFFFF_FFFE);
    run(OP_MUL, 7, 32'hFFFF_FFFD, 0, 0, 6, lat);
    check("mul_res", alu_result, 32'hFFFF_FFEB);
    run(OP_MULHSU, 32'hFFFF_FFFF, 2, 0, 0, 6, lat);
    check("mulhsu_res", alu_result, 32'hFFFF_FFFF);

    drive(OP_DIVU, 100, 7, 0, 0, 4);
    @(negedge clk_in);
    check("div_busy", {31'b0, alu_busy}, 1);
    drive(OP_ADD, 32'h10, 32'h20, 0, 0, 5);
    @(negedge clk_in);
    rs_to_alu_ready = 1'b0;
    wait_rdy(2, lat);
    check("divu_lat", lat, 34);
    check("divu_res", alu_result, 14);
    check("divu_rob", 32'(alu_rob_index), 4);
    check("skid_busy", {31'b0, alu_busy}, 1);
    @(negedge clk_in);
    check("skid_rdy", {31'b0, alu_ready}, 1);
    check("skid_res", alu_result, 32'h30);
    check("skid_rob", 32'(alu_rob_index), 5);
    @(negedge clk_in);
    check("drain_busy", {31'b0, alu_busy}, 0);
    check("drain_rdy", {31'b0, alu_ready}, 0);

    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 7, lat);
    check("ovf_lat", lat, SPEC_LAT);
    check("ovf_res", alu_result, 32'h8000_0000);
    run(OP_REM, 32'h1234, 0, 0, 0, 7, lat);
    check("rem0_lat", lat, SPEC_LAT);
    check("rem0_res", alu_result, 32'h1234);
    run(OP_DIVU, 5, 0, 0, 0, 7, lat);
    check("divu0_res", alu_result, 32'hFFFF_FFFF);
    run(OP_REM, 32'hFFFF_FFF9, 2, 0, 0, 7, lat);
    check("rem_lat", lat, 34);
    check("rem_res", alu_result, 32'hFFFF_FFFF);
    run(OP_DIV, 32'hFFFF_FFF9, 2, 0, 0, 7, lat);
    check("div_res", alu_result, 32'hFFFF_FFFD);

    run(OP_ADD, 3, 4, 0, 0, 2, lat);
    rdy_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("frz_rdy", {31'b0, alu_ready}, 1);
    check("frz_res", alu_result, 7);
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("unfrz_rdy", {31'b0, alu_ready}, 0);

    drive(OP_DIV, 100, 3, 0, 0, 6);
    @(negedge clk_in);
    drive(OP_ADD, 1, 1, 0, 0, 7);
    @(negedge clk_in);
    rs_to_alu_ready = 1'b0;
    repeat (4) @(negedge clk_in);
    check("clr_pre_busy", {31'b0, alu_busy}, 1);
    clr_in = 1'b1;
    @(negedge clk_in);
    clr_in = 1'b0;
    check("clr_busy", {31'b0, alu_busy}, 0);
    check("clr_rdy", {31'b0, alu_ready}, 0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk_in);
      if (alu_ready) cnt++;
    end
    check("clr_quiet", cnt, 0);
    run(OP_ADD, 7, 8, 0, 0, 9, lat);
    check("post_lat", lat, 1);
    check("post_res", alu_result, 15);
    check("post_rob", 32'(alu_rob_index), 9);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Execution stage directly downstream of the reservation station; consumes its rs_to_alu_* issue bundle.
- Computes RV32I integer, jump and branch results, plus RV32M multiply/divide.
- Broadcasts a registered result on the ALU completion bus (alu_ready/alu_result/alu_rob_index) to RS, LSB and ROB, together with branch resolution.
- Multi-cycle ops assert alu_busy; a one-entry skid buffer absorbs the op already in flight when busy rises.

Parameters:
DIV_ITERS, 32, restoring-divider iteration count (one quotient bit per cycle)
MUL_LAT, 2, multiply latency in cycles from accept to alu_ready

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low freezes all state
clr_in  in  1  misprediction flush
rs_to_alu_ready  in  1  issue valid
rs_to_alu_op  in  OPENUM_TYPE  operation enum
rs_to_alu_rs1  in  32  operand A
rs_to_alu_rs2  in  32  operand B
rs_to_alu_rob_index  in  ROB_INDEX_TYPE  destination ROB tag
rs_to_alu_PC  in  32  instruction PC
rs_to_alu_imm  in  32  immediate
alu_busy  out  1  RS must not issue while high
alu_ready  out  1  result valid, single-cycle pulse
alu_result  out  32  rd value
alu_rob_index  out  ROB_INDEX_TYPE  tag of result
alu_is_br  out  1  result belongs to branch/JAL/JALR
alu_taken  out  1  redirect to alu_target
alu_target  out  32  resolved next PC

Behaviour:
- Reset or clr_in (same edge):
  - alu_ready, alu_busy, alu_is_br and alu_taken are 0; alu_result, alu_target and alu_rob_index are 0.
  - FSM returns to IDLE and the skid entry is invalidated.
  - clr_in takes priority over a same-cycle accept.
- rdy_in low: no register changes; a pending alu_ready stays high until rdy_in returns.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: accept on rs_to_alu_ready or a valid skid entry. The skid entry is served first.
- Single-cycle ops are accepted at edge N and produce an alu_ready pulse in cycle N+1. The FSM stays in IDLE.
  - ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND use rs2 as operand B. The *I forms use imm.
  - Shift amount is operand B[4:0]. SRA is arithmetic.
  - LUI returns imm. AUIPC returns PC+imm.
  - JAL: result PC+4, target PC+imm.
  - JALR: result PC+4, target (rs1+imm)&~1.
  - For both jumps, alu_is_br=1 and alu_taken=1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: alu_is_br=1, alu_taken=condition, target = PC+imm if taken else PC+4, result 0.
  - For any non-branch op, alu_is_br=0 and alu_taken=0.
- MUL/MULH/MULHSU/MULHU:
  - IDLE->MUL, with a 64-bit product built from 33-bit sign/zero-extended operands.
  - alu_ready appears MUL_LAT cycles after accept, then the FSM returns to IDLE.
- DIV/DIVU/REM/REMU:
  - IDLE->DIV: take absolute values and run DIV_ITERS restoring iterations.
  - DIV->DONE: apply the sign fix (quotient negated when signs differ; remainder takes the dividend's sign). alu_ready is asserted in DONE, then DONE->IDLE.
  - Latency: DIV_ITERS+2 cycles.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- alu_busy = (state != IDLE) || skid_valid || (accept of a multi-cycle op this cycle, combinational).
- Skid buffer: an rs_to_alu_ready arriving while state != IDLE is captured into one skid entry.
  - A second arrival while the skid entry is valid is a protocol violation (assertion).
- At most one alu_ready pulse per cycle; results retire in accept order.

Optional Feature:
- Macro: ALU_DIV_BYPASS_EN.
- Defined: divide by zero and signed overflow are detected at accept and complete like single-cycle ops (alu_ready at N+1, no DIV state). alu_busy stays low for those ops.
- Undefined: these cases run the full DIV path. They give identical result values at latency DIV_ITERS+2.

Decomposition:
- Shared def package: OPENUM_TYPE and op enum values, ROB_INDEX_TYPE, DATA_TYPE/ADDR_TYPE, TRUE/FALSE.
- Local constants: FSM state encoding.
- Natural sub-module: alu_divider. It holds the iterative restoring divider with start/done handshake, signedness, divide-by-zero and overflow handling.

Test Plan:
- ADD rs1=5 rs2=0xFFFFFFFD at edge N -> alu_ready in N+1, result 2, rob_index echoed. SRA 0x80000000 by 4 -> 0xF8000000.
- BLT PC=0x100 imm=0x20 rs1=-1 rs2=0 -> alu_is_br=1, taken=1, target 0x120. BGEU same operands -> taken=1. JALR rs1=0x203 imm=0 -> result PC+4, target 0x202.
- MULH 0x80000000 x 0x80000000 -> 0x40000000 after MUL_LAT; alu_busy high meanwhile.
- DIVU 100/7 -> 14 at N+34. Next op, arriving the cycle after accept, is held in skid and issued after DONE; alu_busy stays high until the skid drains.
- DIV 0x80000000 / -1 -> 0x80000000. REM x/0 -> x. Check latency 1 with ALU_DIV_BYPASS_EN and 34 without.
- clr_in mid-DIV with skid valid -> no alu_ready afterwards, alu_busy 0 next cycle, fresh ADD completes normally.
